// File: rtl/avr_io_uart_tx_if.sv
// avr_io_uart_tx_if: CPU data-bus port of the UART transmitter
interface avr_io_uart_tx_if;
  logic [15:0] data_addr;
  logic        data_wen;
  logic        data_ren;
  logic [7:0]  data_write;
  logic [7:0]  data_read;
  modport master(output data_addr, data_wen, data_ren, data_write, input data_read);
  modport slave(input data_addr, data_wen, data_ren, data_write, output data_read);
endinterface

// File: rtl/avr_io_uart_tx.sv
// avr_io_uart_tx: memory-mapped 8N1 UART transmitter with a small transmit FIFO
module avr_io_uart_tx #(
  parameter logic [15:0] BASE        = 16'h8000,
  parameter logic [15:0] DEFAULT_DIV = 16'd104,
  parameter int          FIFO_BITS   = 2
) (
  input  logic               clk,
  input  logic               reset,
  avr_io_uart_tx_if.slave    bus,
  output logic               tx,
  output logic               irq
);
  localparam int DEPTH = 1 << FIFO_BITS;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [FIFO_BITS-1:0] wptr, rptr;
  logic [FIFO_BITS:0] count;
  logic [15:0] div, cnt, cnt_n, div_m1;
  logic [7:0] shift, shift_n, status, rd_mux;
  logic [2:0] idx, idx_n;
  logic [1:0] off;
  logic ovf, tx_n, sel, full, empty, busy, wr_data, push, pop, bit_end;
  assign off     = bus.data_addr[1:0];
  assign sel     = bus.data_addr[15] && bus.data_addr[14:2] == BASE[14:2];
  assign full    = count[FIFO_BITS];
  assign empty   = count == '0;
  assign busy    = state != IDLE;
  assign wr_data = bus.data_wen && sel && off == 2'd0;
  assign push    = wr_data && !full;
  assign pop     = state == IDLE && !empty;
  assign status  = {4'h0, ovf, busy, empty, full};
  assign rd_mux  = off == 2'd1 ? status : off == 2'd2 ? div[7:0] : off == 2'd3 ? div[15:8] : 8'h00;
  // Divisor is captured into the down-counter at each bit start, so edits never cut a bit short.
  assign div_m1  = div == '0 ? '0 : div - 16'd1;
  assign bit_end = cnt == '0;
  assign irq     = (empty && !busy) || ovf;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    case (state)
      IDLE: if (!empty) begin
        state_n = START;
        shift_n = mem[rptr];
        cnt_n   = div_m1;
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n   = 3'd0;
        cnt_n   = div_m1;
      end else cnt_n = cnt - 16'd1;
      DATA: if (bit_end) begin
        state_n = idx == 3'd7 ? STOP : DATA;
        shift_n = shift >> 1;
        idx_n   = idx + 3'd1;
        cnt_n   = div_m1;
      end else cnt_n = cnt - 16'd1;
      STOP: if (bit_end) state_n = IDLE;
            else cnt_n = cnt - 16'd1;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      tx            <= 1'b1;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      div           <= DEFAULT_DIV;
      bus.data_read <= 8'h00;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      shift         <= shift_n;
      tx            <= tx_n;
      wptr          <= push ? wptr + 1'b1 : wptr;
      rptr          <= pop ? rptr + 1'b1 : rptr;
      count         <= count + (FIFO_BITS+1)'(push) - (FIFO_BITS+1)'(pop);
      ovf           <= (wr_data && full) ? 1'b1 :
                       (bus.data_wen && sel && off == 2'd1 && bus.data_write[3]) ? 1'b0 : ovf;
      if (bus.data_wen && sel && off == 2'd2) div[7:0] <= bus.data_write;
      if (bus.data_wen && sel && off == 2'd3) div[15:8] <= bus.data_write;
      bus.data_read <= (bus.data_ren && sel) ? rd_mux : 8'h00;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= bus.data_write;
endmodule

// File: tb/tb_avr_io_uart_tx.sv
// tb_avr_io_uart_tx: scoreboard bench; expected frames and read data are queued at issue time
module tb_avr_io_uart_tx;
  localparam logic [15:0] BASE = 16'h8000;
  typedef struct { logic [7:0] d; int p0; int p; bit b2b; } frame_t;
  logic clk = 1'b0, reset = 1'b0, tx, irq, ren_q;
  int tests = 0, fails = 0, cyc = 0, last_end = 0;
  frame_t txq[$];
  logic [7:0] rq[$];
  avr_io_uart_tx_if bus();
  avr_io_uart_tx #(.BASE(BASE), .DEFAULT_DIV(16'd104), .FIFO_BITS(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .irq(irq));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.data_addr = a; bus.data_write = d; bus.data_wen = 1'b1;
    @(negedge clk);
    bus.data_wen = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    rq.push_back(e);
    bus.data_addr = a; bus.data_ren = 1'b1;
    @(negedge clk);
    bus.data_ren = 1'b0;
  endtask
  task automatic set_div(input logic [15:0] v);
    wr(BASE + 16'd2, v[7:0]);
    wr(BASE + 16'd3, v[15:8]);
  endtask
  task automatic wait_idle;
    int n = 0;
    while (!irq && n < 5000) begin @(negedge clk); n++; end
    chk("idle_timeout", 32'(n >= 5000), 0);
    repeat (2) @(negedge clk);
  endtask
  // Read checker: response is due one clock after the strobe.
  always @(posedge clk or posedge reset) ren_q <= reset ? 1'b0 : bus.data_ren;
  always @(negedge clk)
    if (ren_q) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL read_unexpected: got %0h, no read pending", bus.data_read);
      end else chk("read_data", bus.data_read, rq.pop_front());
    end
  // Serial checker: every bit must hold its level for its whole period.
  always begin : txmon
    frame_t e;
    logic [9:0] bits;
    int per, n;
    logic ok, ab;
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      if (txq.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_unexpected: got start bit at %0t, required idle line", $time);
        n = 0;
        while (tx === 1'b0 && !reset && n < 5000) begin @(negedge clk); n++; end
      end else begin
        e = txq.pop_front();
        if (e.b2b) chk("b2b_gap", cyc - last_end, 1);
        bits = {1'b1, e.d, 1'b0};
        ab = 1'b0;
        for (int k = 0; k < 10 && !ab; k++) begin
          per = k == 0 ? e.p0 : e.p;
          ok = 1'b1;
          for (int j = 0; j < per && !ab; j++) begin
            if (reset) ab = 1'b1;
            else begin
              if (tx !== bits[k]) ok = 1'b0;
              @(negedge clk);
            end
          end
          if (!ab) chk($sformatf("tx_bit%0d_byte%02h", k, e.d), ok, 1);
        end
        last_end = cyc;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, d;
    logic [7:0] b [5];
    bus.data_addr = '0; bus.data_wen = 1'b0; bus.data_ren = 1'b0; bus.data_write = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_irq", irq, 1);
    chk("reset_rd", bus.data_read, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd(BASE + 16'd2, 8'h68);
    rd(BASE + 16'd3, 8'h00);
    rd(16'h0123, 8'h00);
    rd(16'h8006, 8'h00);
    rd(16'h0002, 8'h00);
    rd(BASE + 16'd1, 8'h02);
    rd(BASE, 8'h00);
    // single A5 frame at DIV=4
    set_div(16'd4);
    txq.push_back('{8'hA5, 4, 4, 1'b0});
    wr(BASE, 8'hA5);
    @(negedge clk);
    rd(BASE + 16'd1, 8'h06);
    wait_idle();
    chk("irq_after_frame", irq, 1);
    // burst of six: five accepted, the sixth overflows
    for (int i = 0; i < 5; i++) txq.push_back('{8'(8'h10 + i), 4, 4, i > 0});
    for (int i = 0; i < 6; i++) wr(BASE, 8'(8'h10 + i));
    rd(BASE + 16'd1, 8'h0D);
    chk("irq_ovf", irq, 1);
    wr(BASE + 16'd1, 8'h08);
    chk("irq_ovf_cleared", irq, 0);
    rd(BASE + 16'd1, 8'h05);
    wait_idle();
    // divisor zero behaves as one clock per bit
    set_div(16'd0);
    rd(BASE + 16'd2, 8'h00);
    txq.push_back('{8'hFF, 1, 1, 1'b0});
    wr(BASE, 8'hFF);
    wait_idle();
    // divisor change in the middle of the start bit
    set_div(16'd4);
    txq.push_back('{8'h3C, 4, 8, 1'b0});
    wr(BASE, 8'h3C);
    @(negedge clk);
    @(negedge clk);
    wr(BASE + 16'd2, 8'd8);
    wait_idle();
    // randomized bursts
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 6);
      k = $urandom_range(1, 5);
      set_div(16'(d));
      rd(BASE + 16'd2, 8'(d));
      for (int i = 0; i < k; i++) begin
        b[i] = 8'($urandom);
        txq.push_back('{b[i], d == 0 ? 1 : d, d == 0 ? 1 : d, i > 0});
      end
      for (int i = 0; i < k; i++) wr(BASE, b[i]);
      rd(BASE + 16'd1, k == 1 ? 8'h00 : (k == 5 ? 8'h05 : 8'h04));
      wait_idle();
    end
    // reset in the middle of data bit 3
    set_div(16'd4);
    txq.push_back('{8'hC3, 4, 4, 1'b0});
    wr(BASE, 8'hC3);
    wr(BASE, 8'h11);
    wr(BASE, 8'h22);
    repeat (16) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midframe_reset_tx", tx, 1);
    chk("midframe_reset_irq", irq, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(BASE + 16'd1, 8'h02);
    rd(BASE + 16'd2, 8'h68);
    repeat (300) @(negedge clk);
    chk("post_reset_tx_idle", tx, 1);
    chk("txq_drained", txq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
